// File: rtl/bit_ram_pkg.sv
// rtl/bit_ram_pkg.sv - shared constants and state type for the bit_ram loader and reader
//
// Purpose: word/address geometry of the bit_ram serial-bit store and the loader FSM
//          state encoding. The reader side imports the same package so both agree on
//          the {word, bit} read-address split.
// Contents:
//   DATA_W         word width written to bit_ram (bit 0 = first received bit)
//   ADDR_W         word address width
//   DEPTH          number of words, 2**ADDR_W
//   BIT_IDX_W      width of a bit index within a word
//   loader_state_t IDLE / FILL / DONE

package bit_ram_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int BIT_IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bit_shift_packer.sv
// rtl/bit_shift_packer.sv - serial-to-parallel packer with bit counter and zero pad
//
// Purpose: collects serial bits LSB-first into a DATA_W-bit word and flags when a
//          word is ready to commit, either because it filled up or because a pad
//          request arrived with at least one bit collected.
// Ports:
//   clk_in     in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   drop any partial word and restart at bit 0
//   shift_en   in   accept bit_in this cycle at index bit_cnt
//   bit_in     in   serial data bit
//   pad        in   commit the partial word this cycle (upper bits zero)
//   word       out  word to commit, including this cycle's accepted bit (combinational)
//   word_done  out  word is to be committed this cycle (combinational)

module bit_shift_packer
    import bit_ram_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    input  logic              pad,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);

    logic [DATA_W-1:0]    shreg;
    logic [BIT_IDX_W-1:0] bit_cnt;
    logic                 last_bit;

    // shreg is zeroed after every commit, so bits above bit_cnt are already the pad.
    always_comb begin
        word = shreg;
        if (shift_en) begin
            word[bit_cnt] = bit_in;
        end
        last_bit  = shift_en && (bit_cnt == BIT_IDX_W'(DATA_W - 1));
        // A bit accepted alongside pad counts first; a full word suppresses the pad word.
        word_done = last_bit || (pad && (shift_en || (bit_cnt != '0)));
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear || word_done) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= word;
            bit_cnt <= bit_cnt + BIT_IDX_W'(1);
        end
    end

endmodule

// File: rtl/bit_ram_loader.sv
// rtl/bit_ram_loader.sv - packs a serial bit stream into words on the bit_ram write port
//
// Purpose: bit k of the stream since start lands in word k/DATA_W, bit k%DATA_W.
//          Each completed word is written one clock after its last bit is accepted.
// Configuration macro: BIT_RAM_LOADER_WRAP_EN
//   defined   - address wraps after word DEPTH-1 (ring buffer), full stays 0,
//               words_written saturates at DEPTH
//   undefined - the write to word DEPTH-1 sets full and ends the load
// Ports:
//   clk_in         in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   pulse: restart load at word 0, discard partial word
//   bit_in         in   serial data bit
//   bit_valid      in   bit_in valid this cycle
//   flush          in   pulse: write zero-padded partial word, then finish
//   wren           out  bit_ram write enable, one pulse per word
//   wraddress      out  bit_ram write address
//   data           out  bit_ram write data
//   busy           out  1 while in FILL
//   done           out  1 in DONE until next start
//   full           out  last word written, further bits dropped
//   words_written  out  words committed since start

module bit_ram_loader
    import bit_ram_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              flush,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   words_written
);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              word_done;
    logic              accept;
    logic              pad_req;

    // start wins over everything else in the same cycle.
    assign accept  = bit_valid && (state == FILL) && !full && !start;
    assign pad_req = flush && (state == FILL) && !start;

    bit_shift_packer u_packer (
        .clk_in    (clk_in),
        .rst       (rst),
        .clear     (start),
        .shift_en  (accept),
        .bit_in    (bit_in),
        .pad       (pad_req),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            wren          <= 1'b0;
            wraddress     <= '0;
            data          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            full          <= 1'b0;
            words_written <= '0;
        end else if (start) begin
            state         <= FILL;
            addr          <= '0;
            wren          <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            full          <= 1'b0;
            words_written <= '0;
        end else begin
            wren <= 1'b0;
            if (state == FILL) begin
                if (word_done) begin
                    wren      <= 1'b1;
                    data      <= word;
                    wraddress <= addr;
                    if (words_written != (ADDR_W + 1)'(DEPTH)) begin
                        words_written <= words_written + (ADDR_W + 1)'(1);
                    end
                    if (addr == '1) begin
`ifdef BIT_RAM_LOADER_WRAP_EN
                        addr  <= '0;
`else
                        // addr parks at the last word; full blocks any further accepts.
                        full  <= 1'b1;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                if (flush) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_ram_loader.sv
// tb/tb_bit_ram_loader.sv - randomized self-checking bench for bit_ram_loader

module tb_bit_ram_loader;
    import bit_ram_pkg::*;

    logic              clk_in = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              flush = 1'b0;
    logic              wren;
    logic [ADDR_W-1:0] wraddress;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              full;
    logic [ADDR_W:0]   words_written;

    always #5 clk_in = ~clk_in;

    bit_ram_loader dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .start         (start),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .flush         (flush),
        .wren          (wren),
        .wraddress     (wraddress),
        .data          (data),
        .busy          (busy),
        .done          (done),
        .full          (full),
        .words_written (words_written)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the bits gathered since the last commit, the next word slot,
    // and what the write port should show after the coming edge.
    int m_state;   // 0 idle, 1 loading, 2 finished
    bit m_bits[$];
    int m_slot;
    int m_words;
    bit m_full;
    bit e_wren;
    int e_data;
    int e_addr;

    task automatic model_reset();
        m_state = 0;
        m_bits.delete();
        m_slot  = 0;
        m_words = 0;
        m_full  = 1'b0;
        e_wren  = 1'b0;
        e_data  = 0;
        e_addr  = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input bit b, input bit f);
        bit loading;
        bit commit;
        int d;
        e_wren = 1'b0;
        if (s) begin
            m_state = 1;
            m_bits.delete();
            m_slot  = 0;
            m_words = 0;
            m_full  = 1'b0;
            return;
        end
        loading = (m_state == 1);
        if (loading && !m_full && v) m_bits.push_back(b);
        commit = (m_bits.size() == DATA_W) || (loading && f && m_bits.size() > 0);
        if (commit) begin
            d = 0;
            foreach (m_bits[i]) d = d + (int'(m_bits[i]) * (1 << i));
            e_wren  = 1'b1;
            e_data  = d;
            e_addr  = m_slot;
            m_bits.delete();
            m_words = (m_words + 1 > DEPTH) ? DEPTH : m_words + 1;
            if (m_slot == DEPTH - 1) begin
`ifdef BIT_RAM_LOADER_WRAP_EN
                m_slot = 0;
`else
                m_full  = 1'b1;
                m_state = 2;
`endif
            end else begin
                m_slot = m_slot + 1;
            end
        end
        if (loading && f) m_state = 2;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".wren"}, wren, e_wren);
        check({tag, ".wraddress"}, wraddress, e_addr);
        check({tag, ".data"}, data, e_data);
        check({tag, ".busy"}, busy, m_state == 1);
        check({tag, ".done"}, done, m_state == 2);
        check({tag, ".full"}, full, m_full);
        check({tag, ".words_written"}, words_written, m_words);
    endtask

    task automatic cycle(input bit s, input bit v, input bit b, input bit f);
        start     = s;
        bit_valid = v;
        bit_in    = b;
        flush     = f;
        model_step(s, v, b, f);
        @(posedge clk_in);
        #1;
        check_outputs("cyc");
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, w[i], 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_outputs("reset");
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // reset in the middle of a word clears everything without a clock edge
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'h001F, 5);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        rst = 1'b1;
        send_bits(16'hFFFF, 16);

        // two back-to-back words
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'hA5C3, 16);
        check("t2_wren0", wren, 1'b1);
        check("t2_data0", data, 16'hA5C3);
        send_bits(16'h0F0F, 16);
        check("t2_data1", data, 16'h0F0F);
        check("t2_addr1", wraddress, 1);
        check("t2_words", words_written, 2);

        // flush of a 4-bit partial word
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'hFFFF, 16);
        send_bits(16'hFFFF, 4);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_data", data, 16'h000F);
        check("t3_addr", wraddress, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_done", done, 1'b1);

        // flush together with the 16th bit: one write only
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'h7FFF, 15);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("t4_data", data, 16'hFFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_nopad", wren, 1'b0);
        check("t4_done", done, 1'b1);

        // restart mid-word discards the partial bits
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'h0055, 7);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'h1234, 16);
        check("t6_addr", wraddress, 0);
        check("t6_data", data, 16'h1234);

        // fill every word
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH * DATA_W; i++) cycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        check("t5_addr", wraddress, DEPTH - 1);
        check("t5_words", words_written, DEPTH);
`ifdef BIT_RAM_LOADER_WRAP_EN
        check("t5_full", full, 1'b0);
        send_bits(16'hBEEF, 16);
        check("t5_wrap_addr", wraddress, 0);
        check("t5_wrap_data", data, 16'hBEEF);
        check("t5_wrap_words", words_written, DEPTH);
`else
        check("t5_full", full, 1'b1);
        check("t5_done", done, 1'b1);
        send_bits(16'hFFFF, 16);
        check("t5_nowrite", wren, 1'b0);
`endif

        // random mix of start, bits and flush
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 47) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
